gc_axi_koprusu: RTL and testbench

- I/O bridge between the core's memory stage and the peripheral bus.
- When the memory stage flags an I/O access, the block captures one load or store and runs it as a single AXI4-Lite master transaction.
- It stalls the memory stage until the transaction completes, then returns sign- or zero-extended load data with a one-cycle valid pulse.
- It sits directly downstream of the core's memory stage.

---
 rtl/gc_axi_koprusu.sv | 255 +++++++++++++++++++++++++
 tb/tb_gc_axi_koprusu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gc_axi_koprusu.sv
// I/O bridge from the core's memory stage to an AXI4-Lite peripheral bus.
// Runs one load or store per request as a single master transaction and stalls the core meanwhile.
module gc_axi_koprusu #(
    parameter int ADRES_GENISLIGI = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       giris_cikis_aktif_i,
    input  logic                       oku_i,
    input  logic                       yaz_i,
    input  logic [ADRES_GENISLIGI-1:0] adres_i,
    input  logic [31:0]                veri_i,
    input  logic [2:0]                 buyruk_turu_i,
    output logic [31:0]                gc_okunan_veri_o,
    output logic                       gc_veri_gecerli_o,
    output logic                       gc_stall_o,
    output logic                       gc_hata_o,
    output logic [ADRES_GENISLIGI-1:0] m_awaddr_o,
    output logic                       m_awvalid_o,
    input  logic                       m_awready_i,
    output logic [31:0]                m_wdata_o,
    output logic [3:0]                 m_wstrb_o,
    output logic                       m_wvalid_o,
    input  logic                       m_wready_i,
    input  logic [1:0]                 m_bresp_i,
    input  logic                       m_bvalid_i,
    output logic                       m_bready_o,
    output logic [ADRES_GENISLIGI-1:0] m_araddr_o,
    output logic                       m_arvalid_o,
    input  logic                       m_arready_i,
    input  logic [31:0]                m_rdata_i,
    input  logic [1:0]                 m_rresp_i,
    input  logic                       m_rvalid_i,
    output logic                       m_rready_o
);

    typedef enum logic [2:0] {
        BOSTA     = 3'd0,
        YAZ       = 3'd1,
        YAZ_YANIT = 3'd2,
        OKU_ADRES = 3'd3,
        OKU_VERI  = 3'd4,
        TAMAM     = 3'd5
    } durum_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic hizasiz_mi(input logic [2:0] f3, input logic [1:0] ofs);
        logic sonuc;
        case (f3)
            F3_H, F3_HU: sonuc = ofs[0];
            F3_W:        sonuc = (ofs != 2'b00);
            default:     sonuc = 1'b0;
        endcase
        return sonuc;
    endfunction

    function automatic logic [3:0] yazma_strobe(input logic [2:0] f3, input logic [1:0] ofs);
        logic [3:0] sonuc;
        case (f3)
            F3_B:    sonuc = 4'b0001 << ofs;
            F3_H:    sonuc = ofs[1] ? 4'b1100 : 4'b0011;
            default: sonuc = 4'b1111;
        endcase
        return sonuc;
    endfunction

    function automatic logic [31:0] yazma_verisi(input logic [2:0] f3, input logic [31:0] v);
        logic [31:0] sonuc;
        case (f3)
            F3_B:    sonuc = {4{v[7:0]}};
            F3_H:    sonuc = {2{v[15:0]}};
            default: sonuc = v;
        endcase
        return sonuc;
    endfunction

    function automatic logic [31:0] yukleme_genislet(input logic [2:0] f3, input logic [1:0] ofs,
                                                     input logic [31:0] rd);
        logic [7:0]  bayt;
        logic [15:0] yarim;
        logic [31:0] sonuc;
        bayt  = rd[{ofs, 3'b000} +: 8];
        yarim = ofs[1] ? rd[31:16] : rd[15:0];
        case (f3)
            F3_B:    sonuc = {{24{bayt[7]}}, bayt};
            F3_BU:   sonuc = {24'd0, bayt};
            F3_H:    sonuc = {{16{yarim[15]}}, yarim};
            F3_HU:   sonuc = {16'd0, yarim};
            default: sonuc = rd;
        endcase
        return sonuc;
    endfunction

    durum_t                     durum_r, durum_sonraki_s;
    logic [ADRES_GENISLIGI-1:0] adres_r;
    logic [2:0]                 funct3_r;
    logic [31:0]                wdata_r;
    logic [3:0]                 wstrb_r;
    logic                       aw_bitti_r, w_bitti_r;
    logic                       awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
    logic [31:0]                okunan_veri_r;
    logic                       veri_gecerli_r, hata_r;

    logic                       istek_s, yazma_s, hizasiz_s, yakala_s;
    logic                       aw_tamam_s, w_tamam_s, aw_bitti_s, w_bitti_s;
    logic                       hata_s, veri_gecerli_s, veri_yukle_s;
    logic [31:0]                yuklenen_s;

    assign istek_s   = giris_cikis_aktif_i & (oku_i | yaz_i);
    assign yazma_s   = yaz_i;
    assign hizasiz_s = hizasiz_mi(buyruk_turu_i, adres_i[1:0]);
    assign yakala_s  = (durum_r == BOSTA) & istek_s;

    assign gc_stall_o = yakala_s | (durum_r inside {YAZ, YAZ_YANIT, OKU_ADRES, OKU_VERI});

    // Next-state decode plus the completion data/flags produced on entry to TAMAM
    always_comb begin
        durum_sonraki_s = durum_r;
        aw_bitti_s      = aw_bitti_r;
        w_bitti_s       = w_bitti_r;
        hata_s          = 1'b0;
        veri_gecerli_s  = 1'b0;
        veri_yukle_s    = 1'b0;
        yuklenen_s      = 32'd0;
        aw_tamam_s      = aw_bitti_r | (awvalid_r & m_awready_i);
        w_tamam_s       = w_bitti_r | (wvalid_r & m_wready_i);
        case (durum_r)
            BOSTA: begin
                aw_bitti_s = 1'b0;
                w_bitti_s  = 1'b0;
                if (istek_s) begin
                    if (hizasiz_s) begin
                        durum_sonraki_s = TAMAM;
                        hata_s          = 1'b1;
                        veri_gecerli_s  = ~yazma_s;
                        veri_yukle_s    = ~yazma_s;
                    end else if (yazma_s) begin
                        durum_sonraki_s = YAZ;
                    end else begin
                        durum_sonraki_s = OKU_ADRES;
                    end
                end else begin
                    durum_sonraki_s = BOSTA;
                end
            end
            YAZ: begin
                aw_bitti_s = aw_tamam_s;
                w_bitti_s  = w_tamam_s;
                if (aw_tamam_s && w_tamam_s) begin
                    durum_sonraki_s = YAZ_YANIT;
                end else begin
                    durum_sonraki_s = YAZ;
                end
            end
            YAZ_YANIT: begin
                if (bready_r && m_bvalid_i) begin
                    durum_sonraki_s = TAMAM;
                    hata_s          = (m_bresp_i != 2'b00);
                end else begin
                    durum_sonraki_s = YAZ_YANIT;
                end
            end
            OKU_ADRES: begin
                if (arvalid_r && m_arready_i) begin
                    durum_sonraki_s = OKU_VERI;
                end else begin
                    durum_sonraki_s = OKU_ADRES;
                end
            end
            OKU_VERI: begin
                if (rready_r && m_rvalid_i) begin
                    durum_sonraki_s = TAMAM;
                    hata_s          = (m_rresp_i != 2'b00);
                    veri_gecerli_s  = 1'b1;
                    veri_yukle_s    = 1'b1;
                    yuklenen_s      = yukleme_genislet(funct3_r, adres_r[1:0], m_rdata_i);
                end else begin
                    durum_sonraki_s = OKU_VERI;
                end
            end
            TAMAM: begin
                durum_sonraki_s = BOSTA;
            end
            default: begin
                durum_sonraki_s = BOSTA;
            end
        endcase
    end

    // State, channel flags and registered bus/core outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_r        <= BOSTA;
            aw_bitti_r     <= 1'b0;
            w_bitti_r      <= 1'b0;
            awvalid_r      <= 1'b0;
            wvalid_r       <= 1'b0;
            bready_r       <= 1'b0;
            arvalid_r      <= 1'b0;
            rready_r       <= 1'b0;
            okunan_veri_r  <= 32'd0;
            veri_gecerli_r <= 1'b0;
            hata_r         <= 1'b0;
        end else begin
            durum_r        <= durum_sonraki_s;
            aw_bitti_r     <= aw_bitti_s;
            w_bitti_r      <= w_bitti_s;
            // Each write channel drops on its own handshake; bready waits for both
            awvalid_r      <= (durum_sonraki_s == YAZ) & ~aw_bitti_s;
            wvalid_r       <= (durum_sonraki_s == YAZ) & ~w_bitti_s;
            bready_r       <= (durum_sonraki_s == YAZ_YANIT);
            arvalid_r      <= (durum_sonraki_s == OKU_ADRES);
            rready_r       <= (durum_sonraki_s == OKU_VERI);
            veri_gecerli_r <= veri_gecerli_s;
            hata_r         <= hata_s;
            if (veri_yukle_s) begin
                okunan_veri_r <= yuklenen_s;
            end
        end
    end

    // Request capture; held untouched for the whole transaction so AXI payloads stay stable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adres_r  <= '0;
            funct3_r <= 3'd0;
            wdata_r  <= 32'd0;
            wstrb_r  <= 4'd0;
        end else if (yakala_s) begin
            adres_r  <= adres_i;
            funct3_r <= buyruk_turu_i;
            wdata_r  <= yazma_verisi(buyruk_turu_i, veri_i);
            wstrb_r  <= yazma_strobe(buyruk_turu_i, adres_i[1:0]);
        end
    end

    assign m_awaddr_o        = {adres_r[ADRES_GENISLIGI-1:2], 2'b00};
    assign m_araddr_o        = {adres_r[ADRES_GENISLIGI-1:2], 2'b00};
    assign m_awvalid_o       = awvalid_r;
    assign m_wvalid_o        = wvalid_r;
    assign m_wdata_o         = wdata_r;
    assign m_wstrb_o         = wstrb_r;
    assign m_bready_o        = bready_r;
    assign m_arvalid_o       = arvalid_r;
    assign m_rready_o        = rready_r;
    assign gc_okunan_veri_o  = okunan_veri_r;
    assign gc_veri_gecerli_o = veri_gecerli_r;
    assign gc_hata_o         = hata_r;

endmodule

// File: tb/tb_gc_axi_koprusu.sv
// Bench for gc_axi_koprusu: directed cases plus randomized loads/stores against an
// AXI4-Lite slave model with random wait states and a transaction-level reference.
module tb_gc_axi_koprusu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        giris_cikis_aktif_i, oku_i, yaz_i;
    logic [31:0] adres_i, veri_i;
    logic [2:0]  buyruk_turu_i;
    logic [31:0] gc_okunan_veri_o;
    logic        gc_veri_gecerli_o, gc_stall_o, gc_hata_o;
    logic [31:0] m_awaddr_o, m_wdata_o, m_araddr_o, m_rdata_i;
    logic [3:0]  m_wstrb_o;
    logic        m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
    logic [1:0]  m_bresp_i, m_rresp_i;
    logic        m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;

    int          n_test = 0;
    int          n_fail = 0;
    logic [31:0] son_yukleme;
    int          stall_say;

    gc_axi_koprusu #(.ADRES_GENISLIGI(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .giris_cikis_aktif_i(giris_cikis_aktif_i), .oku_i(oku_i), .yaz_i(yaz_i),
        .adres_i(adres_i), .veri_i(veri_i), .buyruk_turu_i(buyruk_turu_i),
        .gc_okunan_veri_o(gc_okunan_veri_o), .gc_veri_gecerli_o(gc_veri_gecerli_o),
        .gc_stall_o(gc_stall_o), .gc_hata_o(gc_hata_o),
        .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o),
        .m_wready_i(m_wready_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i),
        .m_bready_o(m_bready_o), .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o),
        .m_arready_i(m_arready_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
        .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_test++;
        if (gozlenen !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    // Reference load result: pick the addressed lane, then extend as funct3 says
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] rd, input logic [1:0] k);
        logic [31:0] sh;
        int          v;
        sh = rd >> (8 * k);
        case (f3)
            3'd0: begin v = int'(sh & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
            3'd1: begin v = int'(sh & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
            3'd4: return sh & 32'hFF;
            3'd5: return sh & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    task automatic slave_temizle();
        m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b0; m_bresp_i = 2'b00;
        m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rresp_i = 2'b00; m_rdata_i = 32'd0;
    endtask

    // One full request; called at a falling edge, returns at the falling edge after TAMAM
    task automatic islem(input logic yukle, input logic [31:0] adr, input logic [2:0] f3,
                         input logic [31:0] wd, input int aw_g, input int w_g, input int b_g,
                         input int ar_g, input int r_g, input logic [1:0] resp, input logic [31:0] rd);
        logic        mis, st, ld, son, bitti, exp_hata;
        logic [1:0]  k;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata, exp_data, exp_addr;
        logic        aw_d, w_d, b_d, ar_d, r_d, aw_hs, w_hs, b_hs, ar_hs, r_hs;
        int          aw_c, w_c, b_c, ar_c, r_c;
        k        = adr[1:0];
        mis      = ((f3 == 3'd1 || f3 == 3'd5) && adr[0]) || (f3 == 3'd2 && k != 2'd0);
        st       = !yukle && !mis;
        ld       = yukle && !mis;
        exp_addr = adr & 32'hFFFF_FFFC;
        exp_strb = (f3 == 3'd0) ? (4'b0001 << k) : (f3 == 3'd1) ? (4'b0011 << k) : 4'b1111;
        exp_wdata = (f3 == 3'd0) ? 32'(wd[7:0]) * 32'h0101_0101 :
                    (f3 == 3'd1) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
        exp_data = mis ? 32'd0 : ref_load(f3, rd, k);
        exp_hata = mis || (resp != 2'b00);
        aw_d = 1'b0; w_d = 1'b0; b_d = 1'b0; ar_d = 1'b0; r_d = 1'b0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        bitti = 1'b0;
        stall_say = 0;
        giris_cikis_aktif_i = 1'b1;
        oku_i = yukle ? 1'b1 : 1'($urandom_range(0, 1));
        yaz_i = !yukle;
        adres_i = adr; veri_i = wd; buyruk_turu_i = f3;
        for (int c = 0; c < 40 && !bitti; c++) begin
            m_awready_i = m_awvalid_o && (aw_c >= aw_g);
            m_wready_i  = m_wvalid_o && (w_c >= w_g);
            m_bvalid_i  = aw_d && w_d && !b_d && (b_c >= b_g);
            m_bresp_i   = resp;
            m_arready_i = m_arvalid_o && (ar_c >= ar_g);
            m_rvalid_i  = ar_d && !r_d && (r_c >= r_g);
            m_rdata_i   = m_rvalid_i ? rd : 32'hDEAD_BEEF;
            m_rresp_i   = resp;
            #1;
            son = (mis && c == 1) || (ld && r_d) || (st && b_d);
            if (gc_stall_o) stall_say++;
            kontrol("valids", 32'({m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o}),
                    32'({st && c >= 1 && !aw_d, st && c >= 1 && !w_d, aw_d && w_d && !b_d,
                         ld && c >= 1 && !ar_d, ar_d && !r_d}));
            kontrol("ctl", 32'({gc_stall_o, gc_veri_gecerli_o, gc_hata_o}),
                    32'({!son, son && yukle, son && exp_hata}));
            if (m_awvalid_o) kontrol("awaddr", m_awaddr_o, exp_addr);
            if (m_wvalid_o) begin
                kontrol("wdata", m_wdata_o, exp_wdata);
                kontrol("wstrb", 32'(m_wstrb_o), 32'(exp_strb));
            end
            if (m_arvalid_o) kontrol("araddr", m_araddr_o, exp_addr);
            if (son) begin
                if (yukle) begin
                    kontrol("load_data", gc_okunan_veri_o, exp_data);
                    son_yukleme = exp_data;
                end else begin
                    kontrol("data_hold", gc_okunan_veri_o, son_yukleme);
                end
                giris_cikis_aktif_i = 1'b0; oku_i = 1'b0; yaz_i = 1'b0;
                bitti = 1'b1;
            end
            aw_hs = m_awvalid_o && m_awready_i;
            w_hs  = m_wvalid_o && m_wready_i;
            b_hs  = m_bvalid_i && m_bready_o;
            ar_hs = m_arvalid_o && m_arready_i;
            r_hs  = m_rvalid_i && m_rready_o;
            @(posedge clk_i);
            if (aw_hs) aw_d = 1'b1; else if (m_awvalid_o) aw_c++;
            if (w_hs) w_d = 1'b1; else if (m_wvalid_o) w_c++;
            if (b_hs) b_d = 1'b1; else if (aw_d && w_d && !b_d) b_c++;
            if (ar_hs) ar_d = 1'b1; else if (m_arvalid_o) ar_c++;
            if (r_hs) r_d = 1'b1; else if (ar_d && !r_d) r_c++;
            @(negedge clk_i);
            slave_temizle();
        end
        if (!bitti) begin
            kontrol("timeout", 32'd0, 32'd1);
            giris_cikis_aktif_i = 1'b0; oku_i = 1'b0; yaz_i = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ld;
        logic [2:0]  f3;
        logic [1:0]  rs;
        logic [2:0]  yuk_kodlari [5];
        yuk_kodlari = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_i = 1'b1;
        giris_cikis_aktif_i = 1'b0; oku_i = 1'b0; yaz_i = 1'b0;
        adres_i = 32'd0; veri_i = 32'd0; buyruk_turu_i = 3'd0;
        slave_temizle();
        son_yukleme = 32'd0;
        repeat (3) @(negedge clk_i);
        kontrol("rst_valids", 32'({m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o}), 32'd0);
        kontrol("rst_ctl", 32'({gc_stall_o, gc_veri_gecerli_o, gc_hata_o}), 32'd0);
        kontrol("rst_rdata", gc_okunan_veri_o, 32'd0);
        kontrol("rst_awaddr", m_awaddr_o, 32'd0);
        kontrol("rst_wdata", m_wdata_o, 32'd0);
        kontrol("rst_wstrb", 32'(m_wstrb_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // LB zero wait: sign-extended top byte, exactly three stall cycles
        islem(1'b1, 32'h2000_0003, 3'd0, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h80AA_BBCC);
        kontrol("lb_stall_cycles", 32'(stall_say), 32'd3);
        kontrol("lb_value", gc_okunan_veri_o, 32'hFFFF_FF80);
        // SH to upper half
        islem(1'b0, 32'h2000_0006, 3'd1, 32'h0000_1234, 0, 0, 0, 0, 0, 2'b00, 32'd0);
        // SW with awready three cycles ahead of a five-cycle-late wready
        islem(1'b0, 32'h2000_0008, 3'd2, 32'hCAFE_F00D, 2, 5, 0, 0, 0, 2'b00, 32'd0);
        kontrol("sw_stall_cycles", 32'(stall_say), 32'd8);
        // Misaligned LW: no bus activity, error and zero data the next cycle
        islem(1'b1, 32'h2000_0002, 3'd2, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h1111_1111);
        kontrol("lw_mis_stall_cycles", 32'(stall_say), 32'd1);
        // LHU with SLVERR still returns the extended data
        islem(1'b1, 32'h2000_0000, 3'd5, 32'd0, 0, 0, 0, 1, 2, 2'b10, 32'h0000_F00D);
        kontrol("lhu_err_value", gc_okunan_veri_o, 32'h0000_F00D);

        // Reset while waiting for read data
        giris_cikis_aktif_i = 1'b1; oku_i = 1'b1; yaz_i = 1'b0;
        adres_i = 32'h2000_0010; buyruk_turu_i = 3'd2;
        @(negedge clk_i);
        kontrol("rst_mid_arvalid", 32'(m_arvalid_o), 32'd1);
        m_arready_i = 1'b1;
        @(negedge clk_i);
        m_arready_i = 1'b0;
        kontrol("rst_mid_rready", 32'(m_rready_o), 32'd1);
        giris_cikis_aktif_i = 1'b0; oku_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        kontrol("rst_mid_valids", 32'({m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o}), 32'd0);
        kontrol("rst_mid_ctl", 32'({gc_stall_o, gc_veri_gecerli_o, gc_hata_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        son_yukleme = 32'd0;
        @(negedge clk_i);
        kontrol("rst_mid_noPulse", 32'({gc_veri_gecerli_o, gc_hata_o}), 32'd0);
        islem(1'b1, 32'h2000_0010, 3'd2, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h1357_9BDF);

        // Random mix, sometimes back-to-back, sometimes with idle cycles
        for (int i = 0; i < 150; i++) begin
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? yuk_kodlari[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            rs = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            islem(ld, {16'h2000, 16'($urandom)}, f3, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), rs, $urandom);
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                #1;
                kontrol("idle_ctl", 32'({gc_stall_o, gc_veri_gecerli_o, gc_hata_o}), 32'd0);
                kontrol("idle_valids", 32'({m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o}), 32'd0);
                @(negedge clk_i);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
